// File: rtl/modmul_arbiter.sv
// Round-robin arbiter in front of one shared pipelined Barrett multiplier.
// Results return to the requester that issued them; modulus changes only when the pipe is empty.
module modmul_arbiter #(
    parameter int FIELD_WIDTH = 16,
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*FIELD_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*FIELD_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [FIELD_WIDTH-1:0]         rsp_r,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [FIELD_WIDTH-1:0]         cfg_s,
    input  logic [FIELD_WIDTH:0]           cfg_m,
    output logic                           mul_valid,
    output logic [FIELD_WIDTH:0]           mul_a,
    output logic [FIELD_WIDTH:0]           mul_b,
    output logic [FIELD_WIDTH-1:0]         mul_s,
    output logic [FIELD_WIDTH:0]           mul_m,
    input  logic [FIELD_WIDTH-1:0]         mul_r
);

    localparam int TAG_WIDTH = $clog2(NUM_REQ);
    localparam int CNT_WIDTH = $clog2(MUL_LATENCY + 2);

    // state | meaning
    // RUN   | grants enabled
    // DRAIN | config pending, waiting for the multiplier pipe to empty
    // CFG   | load new modulus, cfg_ready high for this one cycle
    typedef enum logic [1:0] {RUN, DRAIN, CFG} state_t;

    state_t                 state, state_next;
    logic [TAG_WIDTH-1:0]   ptr;
    logic [TAG_WIDTH-1:0]   grant_idx;
    logic                   grant_any;
    logic                   accept;
    logic [CNT_WIDTH-1:0]   inflight;
    logic [MUL_LATENCY:0]   pipe_valid;
    logic [TAG_WIDTH-1:0]   pipe_tag [0:MUL_LATENCY];
    logic                   tail_valid;
    logic [FIELD_WIDTH-1:0] rsp_r_q;

    // First requesting index at or after the pointer, wrapping around.
    always_comb begin
        int j;
        j         = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!grant_any && req_valid[j]) begin
                grant_any = 1'b1;
                grant_idx = TAG_WIDTH'(j);
            end
        end
        if (state != RUN || cfg_valid) begin
            grant_any = 1'b0;
        end
    end

    assign req_ready  = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    assign accept     = |(req_valid & req_ready);
    assign tail_valid = pipe_valid[MUL_LATENCY];
    assign rsp_valid  = tail_valid ? (NUM_REQ'(1) << pipe_tag[MUL_LATENCY]) : '0;
    assign rsp_r      = tail_valid ? mul_r : rsp_r_q;
    assign cfg_ready  = (state == CFG);

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (cfg_valid) state_next = DRAIN;
            DRAIN:   if (inflight == '0) state_next = CFG;
            CFG:     state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                ptr <= (grant_idx == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_valid <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            mul_valid <= accept;
            if (accept) begin
                mul_a <= {1'b0, req_a[int'(grant_idx)*FIELD_WIDTH +: FIELD_WIDTH]};
                mul_b <= {1'b0, req_b[int'(grant_idx)*FIELD_WIDTH +: FIELD_WIDTH]};
            end
        end
    end

    // Stage 0 lines up with mul_valid; the tail lines up with mul_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid <= '0;
            for (int k = 0; k <= MUL_LATENCY; k++) pipe_tag[k] <= '0;
        end else begin
            pipe_valid <= {pipe_valid[MUL_LATENCY-1:0], accept};
            pipe_tag[0] <= grant_idx;
            for (int k = 1; k <= MUL_LATENCY; k++) pipe_tag[k] <= pipe_tag[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
            rsp_r_q  <= '0;
            mul_s    <= '0;
            mul_m    <= '0;
        end else begin
            inflight <= inflight + CNT_WIDTH'(accept) - CNT_WIDTH'(tail_valid);
            if (tail_valid) rsp_r_q <= mul_r;
            if (state == CFG) begin
                mul_s <= cfg_s;
                mul_m <= cfg_m;
            end
        end
    end

endmodule

// File: tb/tb_modmul_arbiter.sv
// Directed bench for modmul_arbiter with a behavioural 3-stage modular multiplier attached.
module tb_modmul_arbiter;

    localparam int FW = 16;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid, req_ready, rsp_valid;
    logic [NR*FW-1:0]  req_a, req_b;
    logic [FW-1:0]     rsp_r, cfg_s, mul_s, mul_r;
    logic [FW:0]       cfg_m, mul_a, mul_b, mul_m;
    logic              cfg_valid, cfg_ready, mul_valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cfg_cyc = -1;

    int gq[$];
    int gcyc[$];
    int rq_tag[$];
    int rq_r[$];
    int rq_cyc[$];

    logic [FW-1:0] mp [0:2];

    modmul_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_r(rsp_r),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_s(cfg_s), .cfg_m(cfg_m),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_s(mul_s), .mul_m(mul_m), .mul_r(mul_r)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mp[0] <= (mul_valid && mul_s != 0) ? FW'((64'(mul_a) * 64'(mul_b)) % 64'(mul_s)) : '0;
        mp[1] <= mp[0];
        mp[2] <= mp[1];
    end
    assign mul_r = mp[2];

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    gq.push_back(i);
                    gcyc.push_back(cyc);
                end
            end
            if (rsp_valid != '0) begin
                rq_tag.push_back(int'(rsp_valid));
                rq_r.push_back(int'(rsp_r));
                rq_cyc.push_back(cyc);
            end
            if (cfg_ready) cfg_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        gq.delete(); gcyc.delete();
        rq_tag.delete(); rq_r.delete(); rq_cyc.delete();
    endtask

    task automatic set_op(input int i, input logic [FW-1:0] a, input logic [FW-1:0] b);
        req_a[i*FW +: FW] = a;
        req_b[i*FW +: FW] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic do_cfg(input logic [FW-1:0] s, input logic [FW:0] m);
        bit seen;
        seen = 0;
        cfg_s = s; cfg_m = m; cfg_valid = 1'b1;
        for (int k = 0; k < 30 && !seen; k++) begin
            tick();
            if (cfg_ready) seen = 1;
        end
        cfg_valid = 1'b0;
        check("cfg_ready_seen", 64'(seen), 64'd1);
        tick();
    endtask

    task automatic check_rsp(input int idx, input int tag, input int r);
        if (idx < rq_tag.size()) begin
            check($sformatf("rsp%0d_tag", idx), 64'(rq_tag[idx]), 64'(tag));
            check($sformatf("rsp%0d_r", idx), 64'(rq_r[idx]), 64'(r));
        end
    endtask

    task automatic check_grants(input string tag, input int exp[]);
        check({tag, "_count"}, 64'(gq.size()), 64'(exp.size()));
        for (int k = 0; k < exp.size() && k < gq.size(); k++)
            check($sformatf("%s_%0d", tag, k), 64'(gq[k]), 64'(exp[k]));
    endtask

    initial begin
        int mv;
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        cfg_valid = 1'b0; cfg_s = '0; cfg_m = '0;

        // reset values
        do_reset();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_r", 64'(rsp_r), 64'd0);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        check("rst_mul_valid", 64'(mul_valid), 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        check("rst_mul_s", 64'(mul_s), 64'd0);
        check("rst_mul_m", 64'(mul_m), 64'd0);

        // single requester, s=65521, m=floor(2^32/65521)=65551
        do_cfg(16'd65521, 17'd65551);
        check("cfg_mul_s", 64'(mul_s), 64'd65521);
        check("cfg_mul_m", 64'(mul_m), 64'd65551);
        clear_q();
        set_op(1, 16'd3, 16'd5);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        repeat (8) tick();
        check("single_rsp_count", 64'(rq_tag.size()), 64'd1);
        check_rsp(0, 2, 15);
        if (rq_cyc.size() > 0 && gcyc.size() > 0)
            check("single_latency", 64'(rq_cyc[0] - gcyc[0]), 64'd4);
        check("rsp_r_hold", 64'(rsp_r), 64'd15);

        // all four requesters for 8 cycles, pointer restarted at 0
        do_reset();
        do_cfg(16'd65521, 17'd65551);
        clear_q();
        set_op(0, 16'd0, 16'd12345);
        set_op(1, 16'd65520, 16'd65520);
        set_op(2, 16'd3, 16'd5);
        set_op(3, 16'd300, 16'd400);
        req_valid = 4'b1111;
        repeat (8) tick();
        req_valid = '0;
        repeat (8) tick();
        check_grants("rr", '{0, 1, 2, 3, 0, 1, 2, 3});
        check("rr_rsp_count", 64'(rq_tag.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            int exp_r[4] = '{0, 1, 15, 54479};
            check_rsp(k, 1 << (k % 4), exp_r[k % 4]);
        end
        if (rq_cyc.size() == 8)
            check("rr_back_to_back", 64'(rq_cyc[7] - rq_cyc[0]), 64'd7);

        // fairness: req0 always valid, req2 pulses once
        clear_q();
        req_valid = 4'b0001;
        repeat (3) tick();
        req_valid = 4'b0101;
        tick();
        req_valid = 4'b0001;
        repeat (2) tick();
        req_valid = '0;
        repeat (8) tick();
        check_grants("fair", '{0, 0, 0, 2, 0, 0});
        check("fair_rsp_count", 64'(rq_tag.size()), 64'd6);

        // config while three ops are in flight; pointer sits at 1
        clear_q();
        cfg_cyc = -1;
        req_valid = 4'b0111;
        repeat (3) tick();
        req_valid = 4'b1000;
        set_op(3, 16'd20, 16'd30);
        do_cfg(16'd251, 17'd261);
        check("cfg2_mul_s", 64'(mul_s), 64'd251);
        check("cfg2_mul_m", 64'(mul_m), 64'd261);
        tick();
        req_valid = '0;
        repeat (8) tick();
        check_grants("cfgt", '{1, 2, 0, 3});
        check("cfgt_rsp_count", 64'(rq_tag.size()), 64'd4);
        check_rsp(0, 2, 1);
        check_rsp(1, 4, 15);
        check_rsp(2, 1, 0);
        check_rsp(3, 8, 98);
        if (rq_cyc.size() == 4)
            check("cfg_after_drain", 64'(cfg_cyc > rq_cyc[2]), 64'd1);
        if (gcyc.size() == 4)
            check("no_grant_in_drain", 64'(gcyc[3] > cfg_cyc), 64'd1);

        // reset with two ops in flight
        req_valid = 4'b0011;
        repeat (2) tick();
        req_valid = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_q();
        #1;
        check("midrst_mul_valid", 64'(mul_valid), 64'd0);
        check("midrst_rsp_r", 64'(rsp_r), 64'd0);
        check("midrst_mul_s", 64'(mul_s), 64'd0);
        check("midrst_mul_m", 64'(mul_m), 64'd0);
        check("midrst_mul_a", 64'(mul_a), 64'd0);
        mv = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (mul_valid) mv++;
        end
        check("midrst_no_rsp", 64'(rq_tag.size()), 64'd0);
        check("idle_mul_valid", 64'(mv), 64'd0);
        req_valid = 4'b1111;
        #1;
        check("midrst_ptr0", 64'(req_ready), 64'd1);
        req_valid = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modmul_arbiter.md
Name: modmul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one fixed-latency pipelined Barrett modular multiplier among NUM_REQ requesters, e.g. the point-add/double units of the MSM engine.
- Issues at most one multiplication per cycle and tags each operation with its requester ID.
- Routes each result back to the requester that issued it.
- Owns the multiplier's modulus configuration (s, m) and updates it only when the multiplier pipeline is empty.

Parameters:
- FIELD_WIDTH, 16, operand/modulus width.
- NUM_REQ, 4, number of requesters (>=2).
- MUL_LATENCY, 3, cycles from mul_valid/operands at multiplier input to mul_r valid (>=1).
- TAG_WIDTH, $clog2(NUM_REQ), derived localparam; not overridable.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  in  NUM_REQ*FIELD_WIDTH  packed operand a; requester i occupies bits [i*FIELD_WIDTH +: FIELD_WIDTH].
- req_b  in  NUM_REQ*FIELD_WIDTH  packed operand b; same packing as req_a.
- rsp_valid  out  NUM_REQ  one-hot result strobe.
- rsp_r  out  FIELD_WIDTH  result, broadcast to all requesters.
- cfg_valid  in  1  new modulus request.
- cfg_ready  out  1  config accepted.
- cfg_s  in  FIELD_WIDTH  new modulus.
- cfg_m  in  FIELD_WIDTH+1  new Barrett constant.
- mul_valid  out  1  operands valid at multiplier.
- mul_a  out  FIELD_WIDTH+1  zero-extended operand a.
- mul_b  out  FIELD_WIDTH+1  zero-extended operand b.
- mul_s  out  FIELD_WIDTH  registered modulus.
- mul_m  out  FIELD_WIDTH+1  registered Barrett constant.
- mul_r  in  FIELD_WIDTH  multiplier result.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_r=0, cfg_ready=0, mul_valid=0, mul_a=mul_b=0, mul_s=0, mul_m=0, rr pointer=0, all tag-pipe stages invalid, in-flight count=0, FSM=RUN.
- Reset mid-operation: in-flight operations are discarded and no rsp_valid is produced for them. Config must be rewritten after reset.
- FSM states: RUN, DRAIN, CFG.
  - RUN: grant enabled. If cfg_valid=1, go to DRAIN; no grant is issued in that same cycle.
  - DRAIN: no grants. When in-flight count=0, go to CFG.
  - CFG: cfg_ready=1 for exactly one cycle; mul_s<=cfg_s and mul_m<=cfg_m; return to RUN next cycle.
- Grant rule, RUN only:
  - Search req_valid starting at rr pointer, ascending with wrap.
  - The first set bit i gets req_ready[i]=1, driven combinationally from req_valid and state.
  - Acceptance happens at a clock edge where req_valid[i] & req_ready[i].
  - After a grant to i, pointer <= (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Issue: on accept at edge T, mul_a/mul_b <= zero-extended req_a[i]/req_b[i], mul_valid=1 during cycle T+1. Without an accept, mul_valid <= 0 and the operands hold.
- Tag pipe: a MUL_LATENCY+1 deep shift of {valid, tag} aligned to the issue.
  - Result appears in cycle T+1+MUL_LATENCY.
  - In that cycle rsp_valid[tag]=1 and rsp_r=mul_r, taken combinationally from the tail stage.
  - In all other cycles rsp_valid=0 and rsp_r holds its last value.
- Responses have no backpressure; requesters must always accept.
- Throughput: one accept per cycle sustained; back-to-back issues yield back-to-back responses in issue order.
- In-flight count: +1 on accept, −1 on tail-valid. Both in the same cycle leave it unchanged. Maximum is MUL_LATENCY+1.
- cfg_valid is sampled only in RUN. cfg_valid deasserting during DRAIN still completes the CFG write with the current cfg_s/cfg_m; requesters must hold cfg signals until cfg_ready.
- mul_s/mul_m never change while any operation is in flight.

Test Plan:
- Single requester: cfg s=65521, m=2^32/65521 via CFG; req1 a=3, b=5 accepted at edge T -> rsp_valid=4'b0010, rsp_r=15 at cycle T+4; no other rsp_valid pulses.
- All four req_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3; eight consecutive rsp_valid pulses in the same order, each with the correct a*b mod s.
- Fairness: req0 always valid, req2 valid once -> req2 is granted within NUM_REQ cycles of asserting; pointer wraps correctly from 3 to 0.
- Config during traffic: cfg_valid asserted with 3 ops in flight -> no new grants; cfg_ready pulses exactly one cycle after the last response; ops issued afterwards use the new s (e.g. s=251: 20*30 -> 98).
- Reset mid-flight: reset for 1 cycle with 2 ops in flight -> no rsp_valid afterwards; all outputs at reset values; pointer=0.
- Edge cases: zero operands give r=0; a=s-1, b=s-1 gives r=1; no request and no cfg leaves mul_valid=0 indefinitely.
